// File: rtl/star_arb_n.sv
// -----------------------------------------------------------------------------
// star_arb_n
// N-input round-robin AXI-Stream packet arbiter. A single "star" pointer marks
// the highest-priority channel; after each completed packet (TLAST accepted)
// it moves to one past the winning channel. Once a multi-beat packet starts,
// the arbiter locks onto that channel until its TLAST, so packets are never
// interleaved. The merged stream leaves through a one-entry registered stage.
//
// Optional feature macro: STAR_ARB_TDEST_EN
//   When defined, adds res_TDEST carrying the source channel of each beat.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         asynchronous active-high reset
//   src_TDATA   per-channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_TVALID  per-channel valid
//   src_TREADY  per-channel ready (all zero while rst=1)
//   src_TLAST   per-channel end-of-packet
//   res_TDATA   merged data (registered)
//   res_TVALID  merged valid (registered)
//   res_TREADY  downstream ready
//   res_TLAST   merged end-of-packet (registered)
//   res_TDEST   source channel index (registered, STAR_ARB_TDEST_EN only)
// -----------------------------------------------------------------------------
module star_arb_n #(
   parameter int DATA_WIDTH = 8,
   parameter int N_CH       = 4,
   parameter int START_CH   = 0,
   localparam int CH_W      = (N_CH > 2) ? $clog2(N_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_CH*DATA_WIDTH-1:0] src_TDATA,
   input  logic [N_CH-1:0]            src_TVALID,
   output logic [N_CH-1:0]            src_TREADY,
   input  logic [N_CH-1:0]            src_TLAST,
   output logic [DATA_WIDTH-1:0]      res_TDATA,
   output logic                       res_TVALID,
   input  logic                       res_TREADY,
   output logic                       res_TLAST
`ifdef STAR_ARB_TDEST_EN
   ,
   output logic [CH_W-1:0]            res_TDEST
`endif
);

   localparam logic [CH_W-1:0] START_IDX = CH_W'(START_CH);
   localparam logic [CH_W-1:0] LAST_IDX  = CH_W'(N_CH - 1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [CH_W-1:0]       star, star_nxt;
   logic [CH_W-1:0]       cur, cur_nxt;
   logic [CH_W-1:0]       sel;
   logic [CH_W-1:0]       grant_ch;
   logic                  found;
   logic                  grant_any;
   logic                  buf_rdy;
   logic                  accept;
   logic                  beat_valid;
   logic                  beat_last;
   logic [DATA_WIDTH-1:0] beat_data;

   // Channel after c, wrapping by explicit compare so any N_CH works.
   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
      if (c == LAST_IDX) begin
         return {CH_W{1'b0}};
      end else begin
         return c + CH_W'(1);
      end
   endfunction

   assign buf_rdy = !res_TVALID || res_TREADY;

   // Round-robin search: first valid channel at or above star, else the first
   // valid channel below star (which is the wrapped continuation of the scan).
   always_comb begin
      found = 1'b0;
      sel   = {CH_W{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         if (!found && src_TVALID[i] && (i >= int'(star))) begin
            found = 1'b1;
            sel   = CH_W'(i);
         end else begin
            found = found;
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         if (!found && src_TVALID[i]) begin
            found = 1'b1;
            sel   = CH_W'(i);
         end else begin
            found = found;
         end
      end
   end

   // While locked the grant is unconditional on cur, so its TREADY never
   // depends on its own TVALID.
   assign grant_ch  = (state == LOCKED) ? cur : sel;
   assign grant_any = (state == LOCKED) ? 1'b1 : found;

   // Lane mux for the granted channel plus the one-hot ready vector.
   always_comb begin
      beat_data  = {DATA_WIDTH{1'b0}};
      beat_last  = 1'b0;
      beat_valid = 1'b0;
      src_TREADY = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         if (grant_ch == CH_W'(i)) begin
            beat_data     = src_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
            beat_last     = src_TLAST[i];
            beat_valid    = src_TVALID[i];
            src_TREADY[i] = !rst && grant_any && buf_rdy;
         end else begin
            src_TREADY[i] = 1'b0;
         end
      end
   end

   assign accept = grant_any && buf_rdy && beat_valid;

   // Next-state logic for the lock FSM, star pointer and locked channel.
   always_comb begin
      state_nxt = state;
      star_nxt  = star;
      cur_nxt   = cur;
      case (state)
         IDLE: begin
            if (accept && beat_last) begin
               star_nxt = next_ch(sel);
            end else if (accept) begin
               state_nxt = LOCKED;
               cur_nxt   = sel;
            end else begin
               state_nxt = IDLE;
            end
         end
         LOCKED: begin
            if (accept && beat_last) begin
               state_nxt = IDLE;
               star_nxt  = next_ch(cur);
            end else begin
               state_nxt = LOCKED;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         star  <= START_IDX;
         cur   <= {CH_W{1'b0}};
      end else begin
         state <= state_nxt;
         star  <= star_nxt;
         cur   <= cur_nxt;
      end
   end

   // One-entry output stage: load on accept, otherwise clear valid on drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_TVALID <= 1'b0;
         res_TDATA  <= {DATA_WIDTH{1'b0}};
         res_TLAST  <= 1'b0;
`ifdef STAR_ARB_TDEST_EN
         res_TDEST  <= {CH_W{1'b0}};
`endif
      end else if (accept) begin
         res_TVALID <= 1'b1;
         res_TDATA  <= beat_data;
         res_TLAST  <= beat_last;
`ifdef STAR_ARB_TDEST_EN
         res_TDEST  <= grant_ch;
`endif
      end else if (res_TREADY) begin
         res_TVALID <= 1'b0;
      end else begin
         res_TVALID <= res_TVALID;
      end
   end

endmodule

// File: tb/tb_star_arb_n.sv
// -----------------------------------------------------------------------------
// tb_star_arb_n
// Self-checking bench for star_arb_n. Sources are modelled as per-channel beat
// memories; every beat expected on the merged output is pushed to a queue
// when it is loaded and popped when the output handshakes. A second instance
// with three channels exercises non-power-of-two wrap of the star pointer.
// -----------------------------------------------------------------------------
module tb_star_arb_n;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // Main instance: 4 channels, star starts at 0.
   logic [31:0] s_data;
   logic [3:0]  s_valid, s_ready, s_last;
   logic [7:0]  r_data;
   logic        r_valid, r_ready, r_last;
`ifdef STAR_ARB_TDEST_EN
   logic [1:0]  r_dest;
`endif

   // Second instance: 3 channels, star starts at 2.
   logic [23:0] b_data;
   logic [2:0]  b_valid, b_ready, b_last;
   logic [7:0]  b_rdata;
   logic        b_rvalid, b_rlast;
`ifdef STAR_ARB_TDEST_EN
   logic [1:0]  b_rdest;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0]  mem [4][16];
   int          head [4];
   int          tail [4];
   logic [10:0] expq [$];

   int          cyc = 0;
   int          first_hs, first_v, last_v, vcount;
   logic        samp_rv;
   logic [7:0]  samp_rd;
   logic [3:0]  samp_ready;
   logic        samp_pend1;
   logic [1:0]  samp_dest;

   star_arb_n #(.DATA_WIDTH(8), .N_CH(4), .START_CH(0)) dut (
      .clk(clk), .rst(rst),
      .src_TDATA(s_data), .src_TVALID(s_valid), .src_TREADY(s_ready), .src_TLAST(s_last),
      .res_TDATA(r_data), .res_TVALID(r_valid), .res_TREADY(r_ready), .res_TLAST(r_last)
`ifdef STAR_ARB_TDEST_EN
      , .res_TDEST(r_dest)
`endif
   );

   star_arb_n #(.DATA_WIDTH(8), .N_CH(3), .START_CH(2)) dut3 (
      .clk(clk), .rst(rst),
      .src_TDATA(b_data), .src_TVALID(b_valid), .src_TREADY(b_ready), .src_TLAST(b_last),
      .res_TDATA(b_rdata), .res_TVALID(b_rvalid), .res_TREADY(1'b1), .res_TLAST(b_rlast)
`ifdef STAR_ARB_TDEST_EN
      , .res_TDEST(b_rdest)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive_src();
      for (int ch = 0; ch < 4; ch++) begin
         if (head[ch] < tail[ch]) begin
            s_valid[ch]        = 1'b1;
            s_data[ch*8 +: 8]  = mem[ch][head[ch]][7:0];
            s_last[ch]         = mem[ch][head[ch]][8];
         end else begin
            s_valid[ch]        = 1'b0;
            s_data[ch*8 +: 8]  = 8'h00;
            s_last[ch]         = 1'b0;
         end
      end
   endtask

   task automatic push_beat(input int ch, input logic [7:0] data, input logic last, input logic expect_out);
      mem[ch][tail[ch]] = {last, data};
      tail[ch]++;
      if (expect_out) expq.push_back({2'(ch), last, data});
   endtask

   // One clock: sample/score outputs at negedge, then retire accepted beats.
   task automatic tick();
      logic [3:0]  hs;
      logic [10:0] e;
      @(negedge clk);
      cyc++;
      samp_rv    = r_valid;
      samp_rd    = r_data;
      samp_ready = s_ready;
      samp_pend1 = (head[1] < tail[1]);
`ifdef STAR_ARB_TDEST_EN
      samp_dest  = r_dest;
`else
      samp_dest  = 2'd0;
`endif
      if (r_valid) begin
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
         vcount++;
      end
      if (r_valid && r_ready) begin
         e = (expq.size() > 0) ? expq.pop_front() : 11'h7FF;
         check_val("out_data", {24'd0, r_data}, {24'd0, e[7:0]});
         check_val("out_last", {31'd0, r_last}, {31'd0, e[8]});
`ifdef STAR_ARB_TDEST_EN
         check_val("out_dest", {30'd0, r_dest}, {30'd0, e[10:9]});
`endif
      end
      hs = s_valid & s_ready;
      if (hs != 4'd0 && first_hs < 0) first_hs = cyc;
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 4; ch++) begin
         if (hs[ch]) head[ch]++;
      end
      drive_src();
   endtask

   task automatic drain(input int budget);
      int b;
      b = budget;
      while (expq.size() > 0 && b > 0) begin
         tick();
         b--;
      end
      check_val("drain_left", 32'(expq.size()), 32'd0);
      tick();
      tick();
   endtask

   initial begin
      for (int ch = 0; ch < 4; ch++) begin
         head[ch] = 0;
         tail[ch] = 0;
      end
      first_hs = -1; first_v = -1; last_v = -1; vcount = 0;
      s_valid = 4'hF; s_last = 4'hF; s_data = 32'h5A5A_5A5A; r_ready = 1'b1;
      b_valid = 3'b111; b_last = 3'b111; b_data = 24'hC2B1A0;

      // Reset state with every source requesting.
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid", {31'd0, r_valid}, 32'd0);
      check_val("rst_data",  {24'd0, r_data},  32'd0);
      check_val("rst_last",  {31'd0, r_last},  32'd0);
      check_val("rst_ready", {28'd0, s_ready}, 32'd0);
      check_val("rst_ready3", {29'd0, b_ready}, 32'd0);
`ifdef STAR_ARB_TDEST_EN
      check_val("rst_dest", {30'd0, r_dest}, 32'd0);
`endif
      drive_src();
      b_valid = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Three channels: star 2 -> wraps to 0 -> 1 -> 2 -> 0.
      b_valid = 3'b101;
      @(negedge clk);
      check_val("n3_grant_c2", {29'd0, b_ready}, 32'd4);
      @(posedge clk); #1;
      b_valid = 3'b001;
      @(negedge clk);
      check_val("n3_out_c2", {23'd0, b_rvalid, b_rdata}, 32'h1C2);
      check_val("n3_out_last", {31'd0, b_rlast}, 32'd1);
      check_val("n3_grant_c0", {29'd0, b_ready}, 32'd1);
      @(posedge clk); #1;
      b_valid = 3'b101;
      @(negedge clk);
      check_val("n3_out_c0", {23'd0, b_rvalid, b_rdata}, 32'h1A0);
      check_val("n3_star1", {29'd0, b_ready}, 32'd4);
      @(posedge clk); #1;
      b_valid = 3'b111;
      @(negedge clk);
      check_val("n3_wrap0", {29'd0, b_ready}, 32'd1);
      @(posedge clk); #1;
      b_valid = 3'b000;

      // Rotation: every channel continuously offering single-beat packets.
      first_hs = -1; first_v = -1; last_v = -1; vcount = 0;
      for (int r = 0; r < 3; r++) begin
         for (int ch = 0; ch < 4; ch++) begin
            push_beat(ch, 8'(ch*16 + r), 1'b1, 1'b1);
         end
      end
      drive_src();
      drain(40);
      check_val("rot_latency", 32'(first_v - first_hs), 32'd1);
      check_val("rot_count",   32'(vcount), 32'd12);
      check_val("rot_noidle",  32'(last_v - first_v), 32'd11);

      // Atomicity: ch1 three-beat packet while ch2 waits with a single beat.
      begin
         logic seen_after;
         seen_after = 1'b0;
         push_beat(1, 8'h10, 1'b0, 1'b1);
         push_beat(1, 8'h11, 1'b0, 1'b1);
         push_beat(1, 8'h12, 1'b1, 1'b1);
         push_beat(2, 8'h20, 1'b1, 1'b1);
         drive_src();
         for (int t = 0; t < 20 && expq.size() > 0; t++) begin
            tick();
            if (samp_pend1) begin
               check_val("atom_ready2_low", {31'd0, samp_ready[2]}, 32'd0);
            end else if (!seen_after) begin
               check_val("atom_ready2_after", {31'd0, samp_ready[2]}, 32'd1);
               seen_after = 1'b1;
            end else begin
               seen_after = seen_after;
            end
         end
         drain(10);
      end

      // Backpressure: output held on 0x21 for five stalled cycles.
      r_ready = 1'b0;
      push_beat(3, 8'h21, 1'b0, 1'b1);
      push_beat(3, 8'h22, 1'b0, 1'b1);
      push_beat(3, 8'h23, 1'b1, 1'b1);
      push_beat(0, 8'h40, 1'b1, 1'b1);
      drive_src();
      tick();
      for (int t = 0; t < 5; t++) begin
         tick();
         check_val("bp_valid", {31'd0, samp_rv}, 32'd1);
         check_val("bp_data",  {24'd0, samp_rd}, 32'h21);
         check_val("bp_ready", {28'd0, samp_ready}, 32'd0);
`ifdef STAR_ARB_TDEST_EN
         check_val("bp_dest",  {30'd0, samp_dest}, 32'd3);
`endif
      end
      r_ready = 1'b1;
      drain(20);

      // Mid-packet reset on a ch3 four-beat packet.
      push_beat(3, 8'h50, 1'b0, 1'b1);
      push_beat(3, 8'h51, 1'b0, 1'b0);
      push_beat(3, 8'h52, 1'b0, 1'b0);
      push_beat(3, 8'h53, 1'b1, 1'b0);
      drive_src();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_val("mrst_valid", {31'd0, r_valid}, 32'd0);
      check_val("mrst_ready", {28'd0, s_ready}, 32'd0);
      head[3] = tail[3];
      drive_src();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_val("mrst_queue", 32'(expq.size()), 32'd0);

      // After reset the grant order restarts from channel 0.
      for (int ch = 0; ch < 4; ch++) begin
         push_beat(ch, 8'(8'h60 + ch), 1'b1, 1'b1);
      end
      drive_src();
      drain(20);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
